// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: round-robin arbiter of one shared memory bus between a CPU and a debug master
module mio_bus_arbiter #(
    parameter int          TIMEOUT_CYC = 16,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_wea,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        cpu_busy,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [3:0]  dbg_wea,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_done,
    output logic        dbg_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_wea,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        grant_id
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nxt;
    logic        ptr, pick, any_req, timeout, access, resp;
    logic        we_r, err_r;
    logic [3:0]  wea_r;
    logic [31:0] addr_r, wdata_r, rdata_r;
    logic [7:0]  cnt;
    assign any_req = cpu_req | dbg_req;
    assign pick    = (cpu_req & dbg_req) ? ~ptr : dbg_req;
    assign timeout = cnt == 8'(TIMEOUT_CYC - 1);
    assign access  = state == ACCESS;
    assign resp    = state == RESP;
    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end
    // next state: grant from IDLE, finish ACCESS on ack or timeout, RESP lasts one cycle
    always_comb begin
        state_nxt = state;
        if (state == IDLE && any_req) state_nxt = ACCESS;
        if (access && (mem_ack || timeout)) state_nxt = RESP;
        if (resp) state_nxt = IDLE;
    end
    // latch the winner's request at grant, count wait cycles and capture the result
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr      <= 1'b1;
            grant_id <= 1'b0;
            we_r     <= 1'b0;
            wea_r    <= '0;
            addr_r   <= '0;
            wdata_r  <= '0;
            rdata_r  <= '0;
            err_r    <= 1'b0;
            cnt      <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_id <= pick;
                ptr      <= pick;
                we_r     <= pick ? dbg_we : cpu_we;
                wea_r    <= pick ? dbg_wea : cpu_wea;
                addr_r   <= pick ? dbg_addr : cpu_addr;
                wdata_r  <= pick ? dbg_wdata : cpu_wdata;
                cnt      <= '0;
            end
            if (access) begin
                cnt <= cnt + 8'd1;
                if (mem_ack) begin
                    rdata_r <= we_r ? '0 : mem_rdata;
                    err_r   <= 1'b0;
                end else if (timeout) begin
                    rdata_r <= we_r ? '0 : ERR_DATA;
                    err_r   <= 1'b1;
                end
            end
        end
    end
    assign mem_req   = access;
    assign mem_we    = access & we_r;
    assign mem_wea   = (access & we_r) ? wea_r : '0;
    assign mem_addr  = access ? addr_r : '0;
    assign mem_wdata = access ? wdata_r : '0;
    assign cpu_done  = resp & ~grant_id;
    assign dbg_done  = resp & grant_id;
    assign cpu_rdata = cpu_done ? rdata_r : '0;
    assign dbg_rdata = dbg_done ? rdata_r : '0;
    assign cpu_err   = cpu_done & err_r;
    assign dbg_err   = dbg_done & err_r;
    assign cpu_busy  = cpu_req & ~cpu_done;
endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb_mio_bus_arbiter: directed table-driven bench for the two-master bus arbiter
module tb_mio_bus_arbiter;
    logic        clk = 1'b0, rst = 1'b0;
    logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0, mem_ack = 0;
    logic [3:0]  cpu_wea = 0, dbg_wea = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0, mem_rdata = 0;
    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
    logic        cpu_done, cpu_err, cpu_busy, dbg_done, dbg_err, mem_req, mem_we, grant_id;
    logic [3:0]  mem_wea;
    int total = 0, bad = 0;

    typedef struct {
        logic        who;
        logic        we;
        logic [3:0]  wea;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_lat;
        logic [31:0] bus;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_wea;
    } vec_t;
    vec_t tv[7];

    mio_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wea(cpu_wea), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .cpu_err(cpu_err), .cpu_busy(cpu_busy),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_wea(dbg_wea), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done), .dbg_err(dbg_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wea(mem_wea), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string n);
        int   lat;
        logic stable, done_seen;
        if (v.who) begin
            dbg_req = 1; dbg_we = v.we; dbg_wea = v.wea; dbg_addr = v.addr; dbg_wdata = v.wdata;
        end else begin
            cpu_req = 1; cpu_we = v.we; cpu_wea = v.wea; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        tick();
        chk($sformatf("%s mem_req", n), 32'(mem_req), 32'd1);
        chk($sformatf("%s grant_id", n), 32'(grant_id), 32'(v.who));
        chk($sformatf("%s mem_we", n), 32'(mem_we), 32'(v.we));
        chk($sformatf("%s mem_wdata", n), mem_wdata, v.wdata);
        cpu_req = 0; dbg_req = 0;
        cpu_addr = ~v.addr; dbg_addr = ~v.addr; cpu_wea = ~v.wea; dbg_wea = ~v.wea;
        cpu_we = ~v.we; dbg_we = ~v.we; cpu_wdata = ~v.wdata; dbg_wdata = ~v.wdata;
        stable = 1; lat = 0; done_seen = 0;
        while (!done_seen && lat < 40) begin
            if (mem_addr !== v.addr || mem_wea !== v.exp_wea || mem_req !== 1'b1) stable = 0;
            if (lat == v.ack_lat) begin
                mem_ack = 1; mem_rdata = v.bus;
            end
            tick();
            mem_ack = 0; mem_rdata = 32'h0BAD_0BAD;
            lat++;
            done_seen = v.who ? dbg_done : cpu_done;
        end
        chk($sformatf("%s fields stable", n), 32'(stable), 32'd1);
        chk($sformatf("%s latency", n), lat, v.exp_lat);
        chk($sformatf("%s rdata", n), v.who ? dbg_rdata : cpu_rdata, v.exp_rdata);
        chk($sformatf("%s err", n), 32'(v.who ? dbg_err : cpu_err), 32'(v.exp_err));
        chk($sformatf("%s other done", n), 32'(v.who ? cpu_done : dbg_done), 32'd0);
        chk($sformatf("%s mem_req in resp", n), 32'(mem_req), 32'd0);
        tick();
        chk($sformatf("%s done after resp", n), 32'(cpu_done | dbg_done), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_addr[3];
        logic        quiet;
        int          n;
        tv[0] = '{0, 0, 4'h0, 32'h0000_0100, 32'h0, 3, 32'h1234_5678, 4, 32'h1234_5678, 0, 4'h0};
        tv[1] = '{0, 0, 4'h3, 32'h0000_0104, 32'h5, 0, 32'hAAAA_5555, 1, 32'hAAAA_5555, 0, 4'h0};
        tv[2] = '{1, 0, 4'h0, 32'h0000_0200, 32'h0, 1000, 32'h0, 16, 32'hDEAD_BEEF, 1, 4'h0};
        tv[3] = '{0, 0, 4'h0, 32'h0000_0300, 32'h0, 15, 32'hCAFE_F00D, 16, 32'hCAFE_F00D, 0, 4'h0};
        tv[4] = '{1, 1, 4'hA, 32'h0000_0400, 32'h5A5A_A5A5, 2, 32'hFFFF_FFFF, 3, 32'h0, 0, 4'hA};
        tv[5] = '{1, 1, 4'hF, 32'h0000_0500, 32'h0123_4567, 1, 32'h7777_7777, 2, 32'h0, 0, 4'hF};
        tv[6] = '{0, 0, 4'h0, 32'h0000_0600, 32'h0, 14, 32'h0F0F_0F0F, 15, 32'h0F0F_0F0F, 0, 4'h0};

        tick(); tick();
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset done", 32'(cpu_done | dbg_done), 32'd0);
        chk("reset grant_id", 32'(grant_id), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        rst = 1;
        tick();

        for (int i = 0; i < 7; i++) run(tv[i], $sformatf("vec%0d", i));

        rst = 0;
        tick();
        rst = 1;
        cpu_req = 1; cpu_we = 1; cpu_wea = 4'hF; cpu_addr = 32'h10; cpu_wdata = 32'h1111_1111;
        dbg_req = 1; dbg_we = 1; dbg_wea = 4'hF; dbg_addr = 32'h20; dbg_wdata = 32'h2222_2222;
        exp_addr[0] = 32'h10; exp_addr[1] = 32'h20; exp_addr[2] = 32'h10;
        for (int g = 0; g < 3; g++) begin
            n = 0;
            while (!mem_req && n < 10) begin
                tick();
                n++;
            end
            chk($sformatf("rr%0d mem_addr", g), mem_addr, exp_addr[g]);
            chk($sformatf("rr%0d grant_id", g), 32'(grant_id), 32'(g % 2));
            chk($sformatf("rr%0d cpu_busy", g), 32'(cpu_busy), 32'd1);
            mem_ack = 1;
            tick();
            mem_ack = 0;
            chk($sformatf("rr%0d done", g), 32'(g % 2 ? dbg_done : cpu_done), 32'd1);
            chk($sformatf("rr%0d cpu_busy at done", g), 32'(cpu_busy), 32'(g % 2));
        end
        cpu_req = 0; dbg_req = 0;
        tick();

        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h40;
        tick();
        chk("rst-mid grant", 32'(grant_id), 32'd1);
        dbg_req = 0;
        tick(); tick();
        rst = 0;
        tick();
        chk("rst-mid mem_req", 32'(mem_req), 32'd0);
        chk("rst-mid done", 32'(cpu_done | dbg_done), 32'd0);
        chk("rst-mid grant_id", 32'(grant_id), 32'd0);
        rst = 1;
        mem_ack = 1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ack = 0;
        quiet = 1;
        for (int k = 0; k < 3; k++) begin
            if (cpu_done || dbg_done || mem_req) quiet = 0;
            tick();
        end
        chk("idle ack ignored", 32'(quiet), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
- Arbitrates a single shared memory/IO bus between two masters: the CPU data port and a debug/loader port.
- Sequences each access as a request/acknowledge transaction with wait-state support and a timeout.
- Returns completion, read data and an error flag to the granting master.
- Sits between the CPU core and the memory/peripheral bus; the CPU stalls on `cpu_busy` until `cpu_done`.

Parameters:
- `TIMEOUT_CYC`, 16: maximum cycles waiting for `mem_ack` before abort (range 2..255).
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on a timed-out access.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `cpu_req`  in  1  CPU access request; held high until `cpu_done`.
- `cpu_we`  in  1  CPU write (1) / read (0).
- `cpu_wea`  in  4  CPU byte write enables.
- `cpu_addr`  in  32  CPU address.
- `cpu_wdata`  in  32  CPU write data.
- `cpu_rdata`  out  32  read data to CPU; valid while `cpu_done`=1.
- `cpu_done`  out  1  one-cycle completion pulse to CPU.
- `cpu_err`  out  1  asserted with `cpu_done` when the access timed out.
- `cpu_busy`  out  1  CPU request pending and not yet done (stall).
- `dbg_req`, `dbg_we`, `dbg_wea[3:0]`, `dbg_addr[31:0]`, `dbg_wdata[31:0]`: identical semantics for the debug master.
- `dbg_rdata[31:0]`, `dbg_done`, `dbg_err`: identical semantics for the debug master.
- `mem_req`  out  1  bus request; high for the whole transaction.
- `mem_we`  out  1  bus write.
- `mem_wea`  out  4  bus byte enables; 0 on reads.
- `mem_addr`  out  32  bus address.
- `mem_wdata`  out  32  bus write data.
- `mem_rdata`  in  32  bus read data; sampled on the `mem_ack` cycle.
- `mem_ack`  in  1  bus acknowledge; one-cycle pulse.
- `grant_id`  out  1  0=CPU, 1=debug; owner of the current or last transaction.

Behaviour:
- Reset (`rst`=0 at a clock edge): state←IDLE; all outputs 0; `grant_id`←0; round-robin pointer←CPU-preferred; timeout counter←0.
- Reset mid-transaction: abort silently — no done/err pulse, `mem_req` low after that edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is high, latch the winner's `we`/`wea`/`addr`/`wdata` into registers, set `grant_id`, go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only one request high: grant it.
  - Both high: grant the master opposite the pointer's last winner; after reset, CPU wins first.
  - Pointer updates on each grant.
- ACCESS:
  - `mem_req`=1; `mem_*` driven from the latched registers, stable for the whole transaction.
  - Counter increments every cycle.
  - `mem_ack`=1: capture `mem_rdata` (reads) and go to RESP with err=0.
  - Counter reaches `TIMEOUT_CYC` without ack: go to RESP with err=1, rdata=`ERR_DATA`.
  - `mem_ack` on the same cycle as the timeout: ack wins (err=0).
  - `mem_ack` while not in ACCESS: ignored.
- RESP (one cycle):
  - `mem_req`=0; granted master's `done`=1, `rdata`=captured value, `err` per result; other master's outputs 0.
  - On a write, `rdata`=0.
  - Next state IDLE. Back-to-back accesses therefore cost at least 3 cycles (IDLE, ACCESS, RESP), and the other master can win the next grant.
- Minimum latency: request high at edge N → `mem_req` at N+1 → ack in the same cycle → done at N+2.
- Requester protocol:
  - Request and fields are latched only at grant; later changes are ignored.
  - Dropping `req` mid-transaction does not cancel it; done is still pulsed.
  - Request still high in the cycle after done is treated as a new access.
- `cpu_busy` = `cpu_req` & ~`cpu_done` (combinational); the CPU uses it as a stall.
- `mem_wea` is forced to 0 when the latched `we`=0.

Test Plan:
- CPU read, ack 3 cycles after `mem_req`, `mem_rdata`=32'h1234_5678 → `cpu_done` one cycle after ack, `cpu_rdata`=32'h1234_5678, `cpu_err`=0, `grant_id`=0.
- Both request in the same cycle after reset; CPU write addr 0x10, dbg write addr 0x20 → `mem_addr` 0x10 first, then 0x20; with both held, grants alternate CPU/dbg/CPU.
- Debug read, `mem_ack` never asserted, TIMEOUT_CYC=16 → `dbg_done`=1, `dbg_err`=1, `dbg_rdata`=32'hDEAD_BEEF, 16 cycles after `mem_req` rise.
- `mem_ack` on the exact timeout cycle → `err`=0 and real data returned.
- `cpu_wea`=4'b0011 with `cpu_we`=0 → `mem_wea`=0; `cpu_addr` changed after grant → `mem_addr` unchanged until RESP.
- `rst` driven low during ACCESS → `mem_req`=0 and all `done`=0 after the edge; a later ack while IDLE produces no done pulse.
